// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-protocol initiator: header layout, frame sizes,
// width codes and controller states.
package spi_reg_pkg;

   localparam int RW_BIT     = 15;
   localparam int WIDTH_MSB  = 14;
   localparam int WIDTH_LSB  = 13;
   localparam int ADDR_MSB   = 5;
   localparam int ADDR_LSB   = 0;
   localparam int HDR_BITS   = 16;
   localparam int DATA_BITS  = 32;
   localparam int FRAME_BITS = HDR_BITS + DATA_BITS;

   typedef enum logic [1:0] {
      WIDTH_BYTE = 2'b00,
      WIDTH_HALF = 2'b01,
      WIDTH_WORD = 2'b10,
      WIDTH_RSVD = 2'b11
   } txn_width_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HDR   = 3'd2,
      ST_TURN  = 3'd3,
      ST_DATA  = 3'd4,
      ST_HOLD  = 3'd5,
      ST_GAP   = 3'd6
   } state_e;

   function automatic logic [HDR_BITS-1:0] build_header(input logic       rw,
                                                        input logic [1:0] width,
                                                        input logic [5:0] addr);
      logic [HDR_BITS-1:0] hdr;
      hdr                      = 16'h0000;
      hdr[RW_BIT]              = rw;
      hdr[WIDTH_MSB:WIDTH_LSB] = width;
      hdr[ADDR_MSB:ADDR_LSB]   = addr;
      return hdr;
   endfunction

endpackage

// File: rtl/spi_reg_initiator_sck_tick.sv
// Half-period timebase: a CLK_DIV-cycle counter that ticks on the last cycle of each
// half period and tracks the SCK phase while bit periods are running.
module spi_sck_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic toggle_en,
   output logic tick,
   output logic phase
);
   localparam int            CW      = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;

   assign tick  = en && (cnt_q == CNT_MAX);
   assign phase = phase_q;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (!en) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d   = '0;
         phase_d = toggle_en ? ~phase_q : phase_q;
      end else begin
         cnt_d   = cnt_q + CW'(1);
         phase_d = phase_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/spi_reg_initiator.sv
// SPI register-protocol initiator: turns one host request into one framed mode-0 transaction
// and returns read data with a done pulse.
module spi_reg_initiator
   import spi_reg_pkg::*;
#(
   parameter int CLK_DIV     = 4,
   parameter int TURN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        rw,
   input  logic [1:0]  txn_width,
   input  logic [5:0]  addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        spi_cs_n,
   output logic        spi_clk,
   output logic        spi_mosi,
   input  logic        spi_miso
);
   localparam int BCW = 8;

   if (CLK_DIV < 4) begin : g_clk_div_check
      $error("spi_reg_initiator: CLK_DIV must be at least 4");
   end

   state_e                state_q, state_d, after_bits;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d, bit_last;
   logic [FRAME_BITS-1:0] shift_out_q, shift_out_d;
   logic [DATA_BITS-1:0]  shift_in_q, shift_in_d;
   logic [DATA_BITS-1:0]  rdata_q, rdata_d;
   logic                  rw_q, rw_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic                  cs_n_q, cs_n_d, sck_q, sck_d, mosi_q, mosi_d;
   logic                  tick, phase, cur_in_bits, nxt_in_bits, bit_end, load_bit;

   function automatic logic is_bit_state(input state_e s);
      return (s == ST_HDR) || (s == ST_TURN) || (s == ST_DATA);
   endfunction

   spi_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (state_q != ST_IDLE),
      .toggle_en (cur_in_bits),
      .tick      (tick),
      .phase     (phase)
   );

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_out_d = shift_out_q;
      shift_in_d  = shift_in_q;
      rdata_d     = rdata_q;
      rw_d        = rw_q;
      done_d      = 1'b0;
      cur_in_bits = is_bit_state(state_q);
      bit_end     = cur_in_bits && tick && phase;

      case (state_q)
         ST_HDR: begin
            bit_last   = BCW'(HDR_BITS - 1);
            after_bits = (!rw_q && (TURN_CYCLES > 0)) ? ST_TURN : ST_DATA;
         end
         ST_TURN: begin
            bit_last   = BCW'(TURN_CYCLES - 1);
            after_bits = ST_DATA;
         end
         default: begin
            bit_last   = BCW'(DATA_BITS - 1);
            after_bits = ST_HOLD;
         end
      endcase

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_SETUP;
               rw_d        = rw;
               bit_cnt_d   = '0;
               shift_out_d = {build_header(rw, txn_width, addr), rw ? wdata : 32'h0000_0000};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_d = tick ? ST_HDR : ST_SETUP;
         end
         ST_HDR, ST_TURN, ST_DATA: begin
            if (bit_end && (bit_cnt_q == bit_last)) begin
               bit_cnt_d = '0;
               state_d   = after_bits;
            end else if (bit_end) begin
               bit_cnt_d = bit_cnt_q + BCW'(1);
            end else begin
               bit_cnt_d = bit_cnt_q;
            end
         end
         ST_HOLD: begin
            if (tick) begin
               state_d = ST_GAP;
               done_d  = 1'b1;
               rdata_d = rw_q ? rdata_q : shift_in_q;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_GAP: begin
            state_d = tick ? ST_IDLE : ST_GAP;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // MISO is taken on the final cycle of each high half, after the target's synchroniser.
      if ((state_q == ST_DATA) && bit_end) begin
         shift_in_d = {shift_in_q[DATA_BITS-2:0], spi_miso};
      end else begin
         shift_in_d = shift_in_q;
      end

      // A new bit goes out at the start of every low half, and only then.
      nxt_in_bits = is_bit_state(state_d);
      load_bit    = nxt_in_bits && tick && ((state_q == ST_SETUP) || bit_end);
      if (load_bit) begin
         mosi_d      = shift_out_q[FRAME_BITS-1];
         shift_out_d = {shift_out_q[FRAME_BITS-2:0], 1'b0};
      end else if (nxt_in_bits) begin
         mosi_d = mosi_q;
      end else begin
         mosi_d = 1'b0;
      end

      sck_d  = nxt_in_bits ? ((cur_in_bits && tick) ? ~phase : phase) : 1'b0;
      cs_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_out_q <= '0;
         shift_in_q  <= '0;
         rdata_q     <= 32'h0000_0000;
         rw_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         sck_q       <= 1'b0;
         mosi_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_out_q <= shift_out_d;
         shift_in_q  <= shift_in_d;
         rdata_q     <= rdata_d;
         rw_q        <= rw_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cs_n_q      <= cs_n_d;
         sck_q       <= sck_d;
         mosi_q      <= mosi_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rdata    = rdata_q;
   assign spi_cs_n = cs_n_q;
   assign spi_clk  = sck_q;
   assign spi_mosi = mosi_q;

endmodule
